// File: rtl/decode_ctrl_pkg.sv
// Shared opcode, aluop and operand-mux encodings for the ALU control decoder.
// DECODE_CTRL_MEXT_EN enables the M-extension aluop table.
package decode_ctrl_pkg;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MD   = 7'b0000001;

   localparam logic [4:0] ALU_ADD    = 5'b00000;
   localparam logic [4:0] ALU_SUB    = 5'b00001;
   localparam logic [4:0] ALU_SLL    = 5'b00010;
   localparam logic [4:0] ALU_XOR    = 5'b00011;
   localparam logic [4:0] ALU_SRA    = 5'b00100;
   localparam logic [4:0] ALU_SRL    = 5'b00101;
   localparam logic [4:0] ALU_OR     = 5'b00110;
   localparam logic [4:0] ALU_AND    = 5'b00111;
   localparam logic [4:0] ALU_SLT    = 5'b01000;
   localparam logic [4:0] ALU_SLTU   = 5'b01001;
   localparam logic [4:0] ALU_MULHU  = 5'b10000;
   localparam logic [4:0] ALU_MULHSU = 5'b10001;
   localparam logic [4:0] ALU_MULH   = 5'b10010;
   localparam logic [4:0] ALU_MUL    = 5'b10110;
   localparam logic [4:0] ALU_DIV    = 5'b11000;
   localparam logic [4:0] ALU_DIVU   = 5'b11010;
   localparam logic [4:0] ALU_REM    = 5'b11100;
   localparam logic [4:0] ALU_REMU   = 5'b11110;

   localparam logic [1:0] MUX1_RS1  = 2'b00;
   localparam logic [1:0] MUX1_PC   = 2'b01;
   localparam logic [1:0] MUX1_ZERO = 2'b10;

   localparam logic [1:0] MUX2_RS2   = 2'b00;
   localparam logic [1:0] MUX2_SHAMT = 2'b01;
   localparam logic [1:0] MUX2_IMM12 = 2'b10;
   localparam logic [1:0] MUX2_IMM20 = 2'b11;

   typedef struct packed {
      logic [4:0] aluop;
      logic [1:0] mux1;
      logic [1:0] mux2;
      logic       illegal;
   } lane_dec_t;

   function automatic logic [4:0] base_aluop(input logic [2:0] f3);
      logic [4:0] op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic logic [4:0] mext_aluop(input logic [2:0] f3);
      logic [4:0] op;
      case (f3)
         3'b000:  op = ALU_MUL;
         3'b001:  op = ALU_MULH;
         3'b010:  op = ALU_MULHSU;
         3'b011:  op = ALU_MULHU;
         3'b100:  op = ALU_DIV;
         3'b101:  op = ALU_DIVU;
         3'b110:  op = ALU_REM;
         default: op = ALU_REMU;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/decode_ctrl_lane.sv
// Single-lane combinational ALU control decoder.
// DECODE_CTRL_MEXT_EN adds the OP funct7=0000001 multiply/divide group.
module decode_ctrl_lane
   import decode_ctrl_pkg::*;
(
   input  logic       vld_i,
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output lane_dec_t  dec_o
);

   lane_dec_t dec;
   logic      ill;
   logic      shift;

   assign shift = (funct3_i == 3'b001) || (funct3_i == 3'b101);

   always_comb begin
      dec = '0;
      ill = 1'b0;
      case (opcode_i)
         OPC_OP: begin
            if (funct7_i == F7_BASE) begin
               dec.aluop = base_aluop(funct3_i);
            end else if (funct7_i == F7_ALT) begin
               if (funct3_i == 3'b000)
                  dec.aluop = ALU_SUB;
               else if (funct3_i == 3'b101)
                  dec.aluop = ALU_SRA;
               else
                  ill = 1'b1;
`ifdef DECODE_CTRL_MEXT_EN
            end else if (funct7_i == F7_MD) begin
               dec.aluop = mext_aluop(funct3_i);
`endif
            end else begin
               ill = 1'b1;
            end
         end
         OPC_OPIMM: begin
            dec.aluop = base_aluop(funct3_i);
            dec.mux2  = shift ? MUX2_SHAMT : MUX2_IMM12;
            // funct7 only carries meaning for shift-immediates
            if (shift) begin
               if (funct7_i == F7_ALT && funct3_i == 3'b101)
                  dec.aluop = ALU_SRA;
               else if (funct7_i != F7_BASE && funct7_i != F7_ALT)
                  ill = 1'b1;
            end
         end
         OPC_LUI: begin
            dec.mux1 = MUX1_ZERO;
            dec.mux2 = MUX2_IMM20;
         end
         OPC_AUIPC: begin
            dec.mux1 = MUX1_PC;
            dec.mux2 = MUX2_IMM20;
         end
         default: ill = 1'b1;
      endcase
      if (ill || !vld_i)
         dec = '0;
      dec.illegal = ill && vld_i;
   end

   assign dec_o = dec;

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered multi-lane ALU control decode with skid buffer and illegal counter.
// DECODE_CTRL_MEXT_EN enables M-extension decode in every lane.
module decode_ctrl_stage
   import decode_ctrl_pkg::*;
#(
   parameter int LANES = 2,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES-1:0]   in_lane_vld,
   input  logic [7*LANES-1:0] in_opcode,
   input  logic [3*LANES-1:0] in_funct3,
   input  logic [7*LANES-1:0] in_funct7,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LANES-1:0]   out_lane_vld,
   output logic [5*LANES-1:0] out_aluop,
   output logic [2*LANES-1:0] out_aluin1_mux,
   output logic [2*LANES-1:0] out_aluin2_mux,
   output logic [LANES-1:0]   out_illegal,
   output logic [CNT_W-1:0]   illegal_cnt
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   localparam logic [CNT_W+2:0] CNT_MAX = {3'b000, {CNT_W{1'b1}}};

   state_e                   state_q;
   logic                     in_ready_q;
   lane_dec_t [LANES-1:0]    dec;
   lane_dec_t [LANES-1:0]    out_dec_q;
   lane_dec_t [LANES-1:0]    skid_dec_q;
   logic      [LANES-1:0]    out_lv_q;
   logic      [LANES-1:0]    skid_lv_q;
   logic      [CNT_W-1:0]    cnt_q;
   logic      [CNT_W-1:0]    cnt_d;
   logic      [CNT_W+2:0]    cnt_sum;
   logic                     acc;
   logic                     cons;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      decode_ctrl_lane u_lane (
         .vld_i    (in_lane_vld[i]),
         .opcode_i (in_opcode[7*i +: 7]),
         .funct3_i (in_funct3[3*i +: 3]),
         .funct7_i (in_funct7[7*i +: 7]),
         .dec_o    (dec[i])
      );
      assign out_aluop[5*i +: 5]      = out_dec_q[i].aluop;
      assign out_aluin1_mux[2*i +: 2] = out_dec_q[i].mux1;
      assign out_aluin2_mux[2*i +: 2] = out_dec_q[i].mux2;
      assign out_illegal[i]           = out_dec_q[i].illegal;
   end

   assign out_valid    = (state_q != ST_EMPTY);
   assign in_ready     = in_ready_q;
   assign out_lane_vld = out_lv_q;
   assign illegal_cnt  = cnt_q;

   assign acc  = in_valid && in_ready_q && !flush;
   assign cons = out_valid && out_ready;

   always_comb begin
      cnt_sum = {3'b000, cnt_q};
      for (int i = 0; i < LANES; i++)
         cnt_sum = cnt_sum + (CNT_W+3)'(dec[i].illegal & in_lane_vld[i]);
      cnt_d = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         out_dec_q  <= '0;
         skid_dec_q <= '0;
         out_lv_q   <= '0;
         skid_lv_q  <= '0;
         cnt_q      <= '0;
      end else begin
         if (acc)
            cnt_q <= cnt_d;
         if (flush) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
         end else begin
            case (state_q)
               ST_EMPTY: begin
                  if (acc) begin
                     out_dec_q <= dec;
                     out_lv_q  <= in_lane_vld;
                     state_q   <= ST_ONE;
                  end
               end
               ST_ONE: begin
                  if (acc && cons) begin
                     out_dec_q <= dec;
                     out_lv_q  <= in_lane_vld;
                  end else if (acc) begin
                     skid_dec_q <= dec;
                     skid_lv_q  <= in_lane_vld;
                     state_q    <= ST_TWO;
                     in_ready_q <= 1'b0;
                  end else if (cons) begin
                     state_q <= ST_EMPTY;
                  end
               end
               ST_TWO: begin
                  if (cons) begin
                     out_dec_q  <= skid_dec_q;
                     out_lv_q   <= skid_lv_q;
                     state_q    <= ST_ONE;
                     in_ready_q <= 1'b1;
                  end
               end
               default: begin
                  state_q    <= ST_EMPTY;
                  in_ready_q <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Randomized and directed bench for decode_ctrl_stage against a queue-based model.
module tb_decode_ctrl_stage;

   localparam int L  = 2;
   localparam int CW = 2;
   localparam int CMAX = (1 << CW) - 1;
`ifdef DECODE_CTRL_MEXT_EN
   localparam bit MEXT = 1'b1;
`else
   localparam bit MEXT = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst, flush, in_valid, out_ready;
   logic           in_ready, out_valid;
   logic [L-1:0]   in_lane_vld, out_lane_vld, out_illegal;
   logic [7*L-1:0] in_opcode, in_funct7;
   logic [3*L-1:0] in_funct3;
   logic [5*L-1:0] out_aluop;
   logic [2*L-1:0] out_aluin1_mux, out_aluin2_mux;
   logic [CW-1:0]  illegal_cnt;

   decode_ctrl_stage #(.LANES(L), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_lane_vld(in_lane_vld), .in_opcode(in_opcode),
      .in_funct3(in_funct3), .in_funct7(in_funct7),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_lane_vld(out_lane_vld), .out_aluop(out_aluop),
      .out_aluin1_mux(out_aluin1_mux), .out_aluin2_mux(out_aluin2_mux),
      .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [L-1:0]   lv;
      logic [5*L-1:0] op;
      logic [2*L-1:0] m1;
      logic [2*L-1:0] m2;
      logic [L-1:0]   ill;
   } xfer_t;

   xfer_t q[$];
   int    cnt_m = 0;
   int    checks = 0;
   int    failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // returns {aluop, mux1, mux2, illegal}
   function automatic logic [9:0] ref_lane(input logic v, input logic [6:0] opc,
                                           input logic [2:0] f3, input logic [6:0] f7);
      logic [4:0] base [8];
      logic [4:0] mul [8];
      logic [4:0] a;
      logic [1:0] m1, m2;
      bit ok, sh;
      base = '{5'd0, 5'd2, 5'd8, 5'd9, 5'd3, 5'd5, 5'd6, 5'd7};
      mul  = '{5'd22, 5'd18, 5'd17, 5'd16, 5'd24, 5'd26, 5'd28, 5'd30};
      if (!v) return 10'd0;
      ok = 1'b1; a = 5'd0; m1 = 2'd0; m2 = 2'd0;
      sh = (f3 == 3'd1) || (f3 == 3'd5);
      if (opc == 7'h33) begin
         if (f7 == 7'h00) a = base[f3];
         else if (f7 == 7'h20 && f3 == 3'd0) a = 5'd1;
         else if (f7 == 7'h20 && f3 == 3'd5) a = 5'd4;
         else if (f7 == 7'h01 && MEXT) a = mul[f3];
         else ok = 1'b0;
      end else if (opc == 7'h13) begin
         a  = base[f3];
         m2 = sh ? 2'd1 : 2'd2;
         if (sh && f3 == 3'd5 && f7 == 7'h20) a = 5'd4;
         else if (sh && f7 != 7'h00 && f7 != 7'h20) ok = 1'b0;
      end else if (opc == 7'h37) begin
         m1 = 2'd2; m2 = 2'd3;
      end else if (opc == 7'h17) begin
         m1 = 2'd1; m2 = 2'd3;
      end else begin
         ok = 1'b0;
      end
      if (!ok) return 10'd1;
      return {a, m1, m2, 1'b0};
   endfunction

   function automatic xfer_t ref_xfer();
      xfer_t x;
      logic [9:0] r;
      x = '0;
      x.lv = in_lane_vld;
      for (int i = 0; i < L; i++) begin
         r = ref_lane(in_lane_vld[i], in_opcode[7*i +: 7],
                      in_funct3[3*i +: 3], in_funct7[7*i +: 7]);
         x.op[5*i +: 5] = r[9:5];
         x.m1[2*i +: 2] = r[4:3];
         x.m2[2*i +: 2] = r[2:1];
         x.ill[i]       = r[0];
      end
      return x;
   endfunction

   task automatic step();
      bit    acc, cons;
      xfer_t e;
      int    pop;
      acc  = in_valid && (q.size() < 2) && !flush && !rst;
      cons = (q.size() > 0) && out_ready;
      e    = ref_xfer();
      @(posedge clk);
      #1;
      if (rst || flush) begin
         q.delete();
      end else begin
         if (cons) void'(q.pop_front());
         if (acc) q.push_back(e);
      end
      pop = 0;
      for (int i = 0; i < L; i++) pop += int'(e.ill[i]);
      if (rst) cnt_m = 0;
      else if (acc) cnt_m = (cnt_m + pop > CMAX) ? CMAX : cnt_m + pop;
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("illegal_cnt", 32'(illegal_cnt), 32'(cnt_m));
      if (q.size() > 0) begin
         chk("lane_vld", 32'(out_lane_vld), 32'(q[0].lv));
         chk("aluop", 32'(out_aluop), 32'(q[0].op));
         chk("mux1", 32'(out_aluin1_mux), 32'(q[0].m1));
         chk("mux2", 32'(out_aluin2_mux), 32'(q[0].m2));
         chk("illegal", 32'(out_illegal), 32'(q[0].ill));
      end
   endtask

   task automatic set_lane(input int i, input logic v, input logic [6:0] opc,
                           input logic [2:0] f3, input logic [6:0] f7);
      in_lane_vld[i]       = v;
      in_opcode[7*i +: 7]  = opc;
      in_funct3[3*i +: 3]  = f3;
      in_funct7[7*i +: 7]  = f7;
   endtask

   task automatic rand_lane(input int i);
      logic [6:0] opc, f7;
      case ($urandom_range(0, 5))
         0, 1:    opc = 7'h33;
         2:       opc = 7'h13;
         3:       opc = 7'h37;
         4:       opc = 7'h17;
         default: opc = 7'($urandom);
      endcase
      case ($urandom_range(0, 3))
         0:       f7 = 7'h00;
         1:       f7 = 7'h20;
         2:       f7 = 7'h01;
         default: f7 = 7'($urandom);
      endcase
      set_lane(i, 1'($urandom_range(0, 3) != 0), opc, 3'($urandom), f7);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_lane_vld = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
      #1;
      do_reset();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_aluop", 32'(out_aluop), 32'd0);
      chk("rst_cnt", 32'(illegal_cnt), 32'd0);

      // add + srai
      set_lane(0, 1'b1, 7'h33, 3'd0, 7'h00);
      set_lane(1, 1'b1, 7'h13, 3'd5, 7'h20);
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_aluop", 32'(out_aluop), {22'd0, 5'b00100, 5'b00000});
      chk("t1_mux2", 32'(out_aluin2_mux), 32'b0100);
      step();

      // backpressure: three transfers while stalled
      out_ready = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rand_lane(0);
         rand_lane(1);
         step();
      end
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_depth", 32'(q.size()), 32'd2);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) step();

      // illegal + saturation
      do_reset();
      set_lane(0, 1'b0, 7'h7f, 3'd0, 7'h00);
      set_lane(1, 1'b1, 7'h33, 3'd0, 7'h20);
      in_lane_vld = 2'b01;
      set_lane(0, 1'b1, 7'h7f, 3'd0, 7'h00);
      set_lane(1, 1'b0, 7'h33, 3'd0, 7'h20);
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      chk("ill_flags", 32'(out_illegal), 32'b01);
      chk("ill_aluop0", 32'(out_aluop[4:0]), 32'd0);
      chk("ill_cnt1", 32'(illegal_cnt), 32'd1);
      for (int k = 0; k < 4; k++) step();
      chk("ill_sat", 32'(illegal_cnt), 32'd3);
      in_valid = 1'b0;
      step();

      // fill to TWO then flush with in_valid
      out_ready = 1'b0; in_valid = 1'b1;
      set_lane(0, 1'b1, 7'h33, 3'd4, 7'h00);
      set_lane(1, 1'b1, 7'h33, 3'd6, 7'h00);
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", 32'(out_valid), 32'd0);
      chk("fl_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      step();

      // M-extension div on lane0, LUI/AUIPC pair
      set_lane(0, 1'b1, 7'h33, 3'd4, 7'h01);
      set_lane(1, 1'b1, 7'h37, 3'd0, 7'h00);
      in_valid = 1'b1;
      step();
      chk("m_illegal", 32'(out_illegal[0]), 32'(!MEXT));
      chk("m_aluop", 32'(out_aluop[4:0]), MEXT ? 32'd24 : 32'd0);
      set_lane(0, 1'b1, 7'h37, 3'd0, 7'h00);
      set_lane(1, 1'b1, 7'h17, 3'd0, 7'h00);
      step();
      chk("ui_mux1", 32'(out_aluin1_mux), 32'b0110);
      chk("ui_mux2", 32'(out_aluin2_mux), 32'b1111);
      chk("ui_aluop", 32'(out_aluop), 32'd0);
      in_valid = 1'b0;
      step();

      // random traffic
      for (int k = 0; k < 3000; k++) begin
         in_valid  = 1'($urandom_range(0, 2) != 0);
         out_ready = 1'($urandom_range(0, 3) != 0);
         flush     = 1'($urandom_range(0, 19) == 0);
         rst       = 1'($urandom_range(0, 199) == 0);
         rand_lane(0);
         rand_lane(1);
         step();
      end
      rst = 1'b0; flush = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
